// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register chain.
//   cnt_w      : bit width needed to count 0..depth valid stages
//   MAX_DEPTH  : largest supported chain depth
//   occ_max_t  : occupancy type wide enough for the largest chain
package pipe_pkg;

    localparam int unsigned MAX_DEPTH = 64;

    // Width of a counter that must hold every value from 0 to depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $unsigned($clog2(depth + 1));
    endfunction

    typedef logic [cnt_w(MAX_DEPTH)-1:0] occ_max_t;

endpackage

// File: rtl/pipe_stage.sv
// One stage of the elastic chain: a valid bit plus a payload register.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : stage takes the upstream entry (or bubble) this cycle
//   flush_i   : drop the held entry; payload register keeps its value
//   v_i, d_i  : upstream valid / payload
//   v_o, d_o  : this stage's valid / payload
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Next state: bubbles move forward as valid=0 but never overwrite payload.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (load_i) begin
            v_d = v_i;
            if (v_i) begin
                d_d = d_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= RST_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready pipeline of DEPTH register stages carrying WIDTH bits.
// Supports bubble collapsing, global stall (en), same-cycle flush and an
// occupancy count.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   en                   : 0 freezes every stage and blocks both handshakes
//   flush                : discard all in-flight entries (wins over everything)
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload (0 when idle)
//   occupancy            : number of valid stages
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [cnt_w(DEPTH)-1:0]  occupancy
);

    localparam int unsigned CW = cnt_w(DEPTH);
    typedef logic [CW-1:0] occ_t;

    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [DEPTH-1:0] ready_c;
    logic             in_fire_c;
    logic             out_fire_c;
    occ_t             occ_q, occ_d;

    // Ready ripple in closed form: stage i may advance when enabled and either
    // downstream accepts or some stage at or after i holds a bubble.
    always_comb begin : ready_ripple
        logic full_tail;
        full_tail = 1'b1;
        ready_c   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            full_tail  = full_tail & v_q[i];
            ready_c[i] = en & ~flush & (out_ready | ~full_tail);
        end
    end

    // Stage chain; stage 0 is fed from the input port.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_link
            assign up_v = v_q[i-1];
            assign up_d = d_q[i-1];
        end

        pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load_i  (ready_c[i]),
            .flush_i (flush),
            .v_i     (up_v),
            .d_i     (up_d),
            .v_o     (v_q[i]),
            .d_o     (d_q[i])
        );
    end

    // in_ready is masked by rst because the ripple alone would read 1 on an
    // empty chain while reset is held.
    assign in_ready   = ready_c[0] & ~rst;
    assign out_valid  = v_q[DEPTH-1] & en & ~flush;
    assign out_data   = out_valid ? d_q[DEPTH-1] : '0;

    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;

    // Occupancy tracks handshakes; simultaneous in/out leaves it unchanged.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_fire_c && !out_fire_c) begin
            occ_d = occ_q + occ_t'(1);
        end else if (out_fire_c && !in_fire_c) begin
            occ_d = occ_q - occ_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

`ifndef SYNTHESIS
    // Upstream must hold its payload while stalled.
    a_in_stable: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)));

    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        occ_q <= occ_t'(DEPTH));

    a_depth_legal: assert property (@(posedge clk)
        (DEPTH >= 1) && (DEPTH <= MAX_DEPTH));
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: one DEPTH=3/WIDTH=8 instance and one
// DEPTH=1/WIDTH=1 instance, driven from vector tables plus reset sequences.
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH=3, WIDTH=8 instance
    logic       a_en, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_occ;

    // DEPTH=1, WIDTH=1 instance
    logic       b_en, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic       b_in_data, b_out_data;
    logic       b_occ;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_reg_chain #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    typedef struct {
        logic       en, fl, iv, ordy;
        logic [7:0] din;
        logic       ir, ov;
        logic [7:0] dout;
        int         occ;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int en, input int fl, input int iv, input int din,
                                input int ordy, input int ir, input int ov,
                                input int dout, input int occ);
        vec_t t;
        t.en = 1'(en);  t.fl = 1'(fl);  t.iv = 1'(iv);  t.din = 8'(din);
        t.ordy = 1'(ordy); t.ir = 1'(ir); t.ov = 1'(ov); t.dout = 8'(dout);
        t.occ = occ;
        return t;
    endfunction

    // Called at posedge+1: drive, check handshake outputs, clock, check occupancy.
    task automatic run_vec(input bit sel, input vec_t t, input int idx);
        if (!sel) begin
            a_en = t.en; a_flush = t.fl; a_in_valid = t.iv; a_in_data = t.din;
            a_out_ready = t.ordy;
        end else begin
            b_en = t.en; b_flush = t.fl; b_in_valid = t.iv; b_in_data = t.din[0];
            b_out_ready = t.ordy;
        end
        #2;
        if (!sel) begin
            check($sformatf("A vec%0d in_ready", idx),  a_in_ready,  t.ir);
            check($sformatf("A vec%0d out_valid", idx), a_out_valid, t.ov);
            check($sformatf("A vec%0d out_data", idx),  a_out_data,  t.dout);
        end else begin
            check($sformatf("B vec%0d in_ready", idx),  b_in_ready,  t.ir);
            check($sformatf("B vec%0d out_valid", idx), b_out_valid, t.ov);
            check($sformatf("B vec%0d out_data", idx),  b_out_data,  t.dout);
        end
        @(posedge clk); #1;
        if (!sel) check($sformatf("A vec%0d occupancy", idx), a_occ, t.occ);
        else      check($sformatf("B vec%0d occupancy", idx), b_occ, t.occ);
    endtask

    initial begin
        // ---------------- DEPTH=3 vectors (each segment starts and ends empty)
        //              en fl iv din  or  ir ov dout occ
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 0, 'h00, 0)); // idle after reset
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 0, 'h00, 0));
        // streaming
        va.push_back(mk(1, 0, 1, 'h01, 1, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 1, 'h02, 1, 1, 0, 'h00, 2));
        va.push_back(mk(1, 0, 1, 'h03, 1, 1, 0, 'h00, 3));
        va.push_back(mk(1, 0, 1, 'h04, 1, 1, 1, 'h01, 3));
        va.push_back(mk(1, 0, 1, 'h05, 1, 1, 1, 'h02, 3));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h03, 2));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h04, 1));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h05, 0));
        // backpressure, then pass-through on a full chain
        va.push_back(mk(1, 0, 1, 'h01, 0, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 1, 'h02, 0, 1, 0, 'h00, 2));
        va.push_back(mk(1, 0, 1, 'h03, 0, 1, 0, 'h00, 3));
        va.push_back(mk(1, 0, 1, 'h04, 0, 0, 1, 'h01, 3));
        va.push_back(mk(1, 0, 1, 'h04, 1, 1, 1, 'h01, 3));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h02, 2));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h03, 1));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h04, 0));
        // bubble collapse under backpressure
        va.push_back(mk(1, 0, 1, 'h01, 0, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 0, 'h00, 0, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 1, 'h02, 0, 1, 0, 'h00, 2));
        va.push_back(mk(1, 0, 0, 'h00, 0, 1, 1, 'h01, 2));
        va.push_back(mk(1, 0, 1, 'h03, 0, 1, 1, 'h01, 3));
        va.push_back(mk(1, 0, 1, 'h04, 0, 0, 1, 'h01, 3));
        va.push_back(mk(1, 0, 1, 'h04, 1, 1, 1, 'h01, 3));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h02, 2));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h03, 1));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h04, 0));
        // flush with two entries, nothing old emerges, new data still flows
        va.push_back(mk(1, 0, 1, 'h11, 0, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 1, 'h12, 0, 1, 0, 'h00, 2));
        va.push_back(mk(1, 0, 0, 'h00, 0, 1, 0, 'h00, 2));
        va.push_back(mk(1, 1, 1, 'h13, 1, 0, 0, 'h00, 0));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 0, 'h00, 0));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 0, 'h00, 0));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 0, 'h00, 0));
        va.push_back(mk(1, 0, 1, 'h21, 1, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h21, 0));
        // enable low for 4 cycles mid-stream
        va.push_back(mk(1, 0, 1, 'h31, 1, 1, 0, 'h00, 1));
        va.push_back(mk(1, 0, 1, 'h32, 1, 1, 0, 'h00, 2));
        va.push_back(mk(1, 0, 1, 'h33, 1, 1, 0, 'h00, 3));
        va.push_back(mk(0, 0, 1, 'h34, 1, 0, 0, 'h00, 3));
        va.push_back(mk(0, 0, 1, 'h34, 1, 0, 0, 'h00, 3));
        va.push_back(mk(0, 0, 1, 'h34, 1, 0, 0, 'h00, 3));
        va.push_back(mk(0, 0, 1, 'h34, 1, 0, 0, 'h00, 3));
        va.push_back(mk(1, 0, 1, 'h34, 1, 1, 1, 'h31, 3));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h32, 2));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h33, 1));
        va.push_back(mk(1, 0, 0, 'h00, 1, 1, 1, 'h34, 0));

        // ---------------- DEPTH=1, WIDTH=1 vectors
        vb.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
        vb.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
        // streaming 1,0,1
        vb.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0, 1));
        vb.push_back(mk(1, 0, 1, 0, 1, 1, 1, 1, 1));
        vb.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0, 1));
        vb.push_back(mk(1, 0, 0, 0, 1, 1, 1, 1, 0));
        vb.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
        // backpressure and pass-through
        vb.push_back(mk(1, 0, 1, 1, 0, 1, 0, 0, 1));
        vb.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 1));
        vb.push_back(mk(1, 0, 1, 0, 1, 1, 1, 1, 1));
        vb.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0));
        // flush
        vb.push_back(mk(1, 0, 1, 1, 0, 1, 0, 0, 1));
        vb.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 0));
        vb.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
        // enable
        vb.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0, 1));
        vb.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1));
        vb.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1));
        vb.push_back(mk(1, 0, 1, 0, 1, 1, 1, 1, 1));
        vb.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0));

        // ---------------- initial reset
        rst = 1'b1;
        a_en = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
        b_en = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("A reset in_ready",  a_in_ready,  0);
        check("A reset out_valid", a_out_valid, 0);
        check("A reset out_data",  a_out_data,  0);
        check("A reset occupancy", a_occ,       0);
        check("A reset d0", u_dut_a.g_stage[0].u_stage.d_q, 'hA5);
        check("A reset d1", u_dut_a.g_stage[1].u_stage.d_q, 'hA5);
        check("A reset d2", u_dut_a.g_stage[2].u_stage.d_q, 'hA5);
        check("B reset in_ready",  b_in_ready,  0);
        check("B reset out_valid", b_out_valid, 0);
        check("B reset d0", u_dut_b.g_stage[0].u_stage.d_q, 1);
        rst = 1'b0;

        for (int i = 0; i < va.size(); i++) run_vec(1'b0, va[i], i);

        // ---------------- reset mid-stream on the DEPTH=3 chain
        a_en = 1'b1; a_flush = 1'b0; a_out_ready = 1'b0; a_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in_data = 8'(8'h41 + k);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        a_in_data  = 8'h00;
        #1;
        check("A pre-reset out_valid", a_out_valid, 1);
        check("A pre-reset out_data",  a_out_data,  'h41);
        check("A pre-reset occupancy", a_occ,       3);
        rst = 1'b1;
        #1;
        check("A midreset out_valid", a_out_valid, 0);
        check("A midreset out_data",  a_out_data,  0);
        check("A midreset in_ready",  a_in_ready,  0);
        check("A midreset occupancy", a_occ,       0);
        check("A midreset d0", u_dut_a.g_stage[0].u_stage.d_q, 'hA5);
        check("A midreset d1", u_dut_a.g_stage[1].u_stage.d_q, 'hA5);
        check("A midreset d2", u_dut_a.g_stage[2].u_stage.d_q, 'hA5);
        @(posedge clk); #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("A post-reset%0d out_valid", k), a_out_valid, 0);
            @(posedge clk); #1;
            check($sformatf("A post-reset%0d occupancy", k), a_occ, 0);
        end

        for (int i = 0; i < vb.size(); i++) run_vec(1'b1, vb[i], i);

        // ---------------- reset mid-stream on the DEPTH=1 chain
        b_en = 1'b1; b_flush = 1'b0; b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 1'b0;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        #1;
        check("B pre-reset out_valid", b_out_valid, 1);
        check("B pre-reset occupancy", b_occ,       1);
        rst = 1'b1;
        #1;
        check("B midreset out_valid", b_out_valid, 0);
        check("B midreset occupancy", b_occ,       0);
        check("B midreset d0", u_dut_b.g_stage[0].u_stage.d_q, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        b_out_ready = 1'b1;
        #2;
        check("B post-reset out_valid", b_out_valid, 0);
        @(posedge clk); #1;
        check("B post-reset occupancy", b_occ, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
